// File: rtl/vnu3_ctrl_pkg.sv
// Shared definitions for the VNU3 IB-RAM control FSMs: state encoding,
// write-FSM busy codes and default geometry.
package vnu3_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_REQ       = 3'd1,
    ST_WAIT_LOAD = 3'd2,
    ST_RELEASE   = 3'd3,
    ST_READ      = 3'd4,
    ST_PROC      = 3'd5,
    ST_DONE      = 3'd6
  } rd_state_e;

  localparam logic [1:0] BUSY_IDLE = 2'b00;
  localparam logic [1:0] BUSY_LOAD = 2'b01;
  localparam logic [1:0] BUSY_FIN  = 2'b10;

  localparam int LOAD_CYCLE_DEF = 64;
  localparam int ITER_MAX_DEF   = 10;
  localparam int WDOG_CYCLE_DEF = 256;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for quasi-static multi-bit status from another clock
// domain. The source only changes between stable codes, so per-bit
// synchronization is acceptable.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  // Two-stage capture chain; both stages clear on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      // NOTE: non-blocking assignments make the two stages shift as a real
      // pipeline; blocking here would collapse them into one flop.
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/vnu3_rd_fsm.sv
// VNU3 IB-RAM read-side controller: requests a table load from the write
// FSM, waits for it, sweeps both RAM banks, counts decoding iterations and
// signals termination. Optional handshake watchdog: VNU3_RD_WATCHDOG_EN.
module vnu3_rd_fsm
  import vnu3_ctrl_pkg::*;
#(
  parameter int LOAD_CYCLE = LOAD_CYCLE_DEF,
  parameter int ITER_MAX   = ITER_MAX_DEF
`ifdef VNU3_RD_WATCHDOG_EN
  , parameter int WDOG_CYCLE = WDOG_CYCLE_DEF
`endif
) (
  input  logic                          read_clk,
  input  logic                          rstn,
  input  logic                          start,
  input  logic [1:0]                    wr_busy,
  input  logic                          iter_done,
  input  logic                          syndrome_ok,
  output logic                          iter_rqst,
  output logic                          iter_termination,
  output logic                          ram_rd_en,
  output logic [$clog2(LOAD_CYCLE)-1:0] ram_rd_addr,
  output logic [$clog2(ITER_MAX+1)-1:0] iter_cnt,
  output logic                          decode_done,
  output logic                          handshake_err,
  output logic [2:0]                    state
);

  localparam int AW = $clog2(LOAD_CYCLE);
  localparam int CW = $clog2(ITER_MAX + 1);
  localparam logic [AW-1:0] ADDR_LAST = AW'(LOAD_CYCLE - 1);
  localparam logic [CW-1:0] CNT_MAX   = CW'(ITER_MAX);

  rd_state_e     r_state;
  rd_state_e     w_state_nxt;
  logic [1:0]    w_busy_s;
  logic [AW-1:0] r_addr;
  logic [CW-1:0] r_iter_cnt;
  logic [CW-1:0] w_cnt_inc;
  logic          w_wdog_hit;
  logic          w_rqst;
  logic          w_rd_en;
  logic          w_done;

  sync_2ff #(.WIDTH(2)) u_busy_sync (
    .clk   (read_clk),
    .rst_n (rstn),
    .i_d   (wr_busy),
    .o_q   (w_busy_s)
  );

  // Saturating iteration increment.
  assign w_cnt_inc = (r_iter_cnt == CNT_MAX) ? r_iter_cnt : r_iter_cnt + CW'(1);

  // Next-state and state-decoded outputs.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    w_state_nxt = r_state;
    w_rqst      = 1'b0;
    w_rd_en     = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      ST_IDLE:      if (start) w_state_nxt = ST_REQ;
      ST_REQ: begin
        w_rqst = 1'b1;
        if (w_busy_s == BUSY_LOAD) w_state_nxt = ST_WAIT_LOAD;
      end
      ST_WAIT_LOAD: begin
        w_rqst = 1'b1;
        if (w_busy_s == BUSY_FIN) w_state_nxt = ST_RELEASE;
      end
      ST_RELEASE:   if (w_busy_s == BUSY_IDLE) w_state_nxt = ST_READ;
      ST_READ: begin
        w_rd_en = 1'b1;
        if (r_addr == ADDR_LAST) w_state_nxt = ST_PROC;
      end
      ST_PROC: begin
        if (iter_done)
          w_state_nxt = (syndrome_ok || (w_cnt_inc == CNT_MAX)) ? ST_DONE : ST_REQ;
      end
      ST_DONE: begin
        w_done      = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default:      w_state_nxt = ST_IDLE;
    endcase
    if (w_wdog_hit) w_state_nxt = ST_IDLE;
  end

  // State register.
  always_ff @(posedge read_clk or negedge rstn) begin
    // NOTE: reset drives the FSM and every counter to a known value; none of
    // them may power up undefined.
    if (!rstn) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Sweep address and iteration counter.
  always_ff @(posedge read_clk or negedge rstn) begin
    if (!rstn) begin
      r_addr     <= '0;
      r_iter_cnt <= '0;
    end else begin
      if (r_state == ST_READ)
        r_addr <= (r_addr == ADDR_LAST) ? '0 : r_addr + AW'(1);
      if (r_state == ST_IDLE && start)
        r_iter_cnt <= '0;
      else if (r_state == ST_PROC && iter_done)
        r_iter_cnt <= w_cnt_inc;
    end
  end

`ifdef VNU3_RD_WATCHDOG_EN
  localparam int WW = $clog2(WDOG_CYCLE);

  logic [WW-1:0] r_wdog;
  logic          r_hs_err;
  logic          r_wdog_term;
  logic          w_in_hs;

  assign w_in_hs    = (r_state == ST_REQ) || (r_state == ST_WAIT_LOAD) ||
                      (r_state == ST_RELEASE);
  assign w_wdog_hit = w_in_hs && (r_wdog == WW'(WDOG_CYCLE - 1));

  // Handshake watchdog: counts only while waiting on the writer.
  always_ff @(posedge read_clk or negedge rstn) begin
    if (!rstn) begin
      r_wdog      <= '0;
      r_hs_err    <= 1'b0;
      r_wdog_term <= 1'b0;
    end else begin
      r_wdog_term <= w_wdog_hit;
      if (w_in_hs && !w_wdog_hit) r_wdog <= r_wdog + WW'(1);
      else                        r_wdog <= '0;
      if (r_state == ST_IDLE && start) r_hs_err <= 1'b0;
      else if (w_wdog_hit)             r_hs_err <= 1'b1;
    end
  end

  assign handshake_err    = r_hs_err;
  assign iter_termination = w_done | r_wdog_term;
`else
  assign w_wdog_hit       = 1'b0;
  assign handshake_err    = 1'b0;
  assign iter_termination = w_done;
`endif

  assign iter_rqst   = w_rqst;
  assign ram_rd_en   = w_rd_en;
  assign decode_done = w_done;
  assign ram_rd_addr = r_addr;
  assign iter_cnt    = r_iter_cnt;
  assign state       = r_state;

endmodule

// File: tb/tb_vnu3_rd_fsm.sv
// Self-checking bench for vnu3_rd_fsm. A behavioural write-FSM model reacts
// to iter_rqst; expectations come from the handshake timing, sweep shape and
// iteration-termination rules. Exercises VNU3_RD_WATCHDOG_EN when defined.
module tb_vnu3_rd_fsm;

  localparam int LOAD_CYCLE = 64;
  localparam int ITER_MAX   = 10;

  logic       read_clk = 1'b0;
  logic       rstn;
  logic       start;
  logic [1:0] wr_busy;
  logic       iter_done;
  logic       syndrome_ok;
  logic       iter_rqst;
  logic       iter_termination;
  logic       ram_rd_en;
  logic [5:0] ram_rd_addr;
  logic [3:0] iter_cnt;
  logic       decode_done;
  logic       handshake_err;
  logic [2:0] state;

  int n_checks = 0;
  int n_err    = 0;
  int cyc_n    = 0;

  // Writer model and monitors
  int   w_ph = 0, w_cnt = 0, w_hold = 0;
  bit   w_stuck = 1'b0;
  int   t_wr_idle = -1000, t_rqst_fall = -1000;
  logic prev_rqst = 1'b0;
  int   n_done = 0, n_term = 0;

  always #5 read_clk = ~read_clk;

  vnu3_rd_fsm dut (
    .read_clk         (read_clk),
    .rstn             (rstn),
    .start            (start),
    .wr_busy          (wr_busy),
    .iter_done        (iter_done),
    .syndrome_ok      (syndrome_ok),
    .iter_rqst        (iter_rqst),
    .iter_termination (iter_termination),
    .ram_rd_en        (ram_rd_en),
    .ram_rd_addr      (ram_rd_addr),
    .iter_cnt         (iter_cnt),
    .decode_done      (decode_done),
    .handshake_err    (handshake_err),
    .state            (state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: sample after the edge, update monitors, let the writer react.
  task automatic cyc();
    @(posedge read_clk);
    #1;
    cyc_n++;
    if (decode_done === 1'b1) n_done++;
    if (iter_termination === 1'b1) n_term++;
    if (prev_rqst === 1'b1 && iter_rqst === 1'b0) t_rqst_fall = cyc_n;
    prev_rqst = iter_rqst;
    if (!w_stuck) begin
      case (w_ph)
        0: if (iter_rqst === 1'b1) begin
             w_cnt++;
             if (w_cnt == 3) begin wr_busy = 2'b01; w_ph = 1; w_cnt = 0; end
           end
        1: begin
             w_cnt++;
             if (w_cnt == LOAD_CYCLE) begin wr_busy = 2'b10; w_ph = 2; w_cnt = 0; end
           end
        default: if (iter_rqst === 1'b0) begin
             if (w_cnt == w_hold) begin
               wr_busy = 2'b00; w_ph = 0; w_cnt = 0; t_wr_idle = cyc_n;
             end else w_cnt++;
           end
      endcase
    end
  endtask

  task automatic writer_reset();
    w_ph = 0; w_cnt = 0; wr_busy = 2'b00;
  endtask

  // One codeword decode. ok_iter: iteration whose iter_done carries
  // syndrome_ok (>ITER_MAX means never). rst_iter: iteration in which reset
  // is asserted at sweep address 30 (0 means none).
  task automatic run_decode(input int ok_iter, input int hold, input int rst_iter);
    bit got;
    int exp_final;
    exp_final = (ok_iter < ITER_MAX) ? ok_iter : ITER_MAX;
    w_hold = hold; n_done = 0; n_term = 0;
    start = 1'b1; cyc(); start = 1'b0;
    check("start_rqst", iter_rqst, 1);
    check("start_state", state, 1);
    check("start_cnt_clr", iter_cnt, 0);
    for (int k = 1; k <= ITER_MAX; k++) begin
      // start and iter_done while handshaking must be ignored
      start = 1'b1; iter_done = 1'b1; syndrome_ok = 1'b1;
      cyc();
      start = 1'b0; iter_done = 1'b0; syndrome_ok = 1'b0;
      got = 1'b0;
      for (int i = 0; i < 400 && !got; i++) begin
        if (ram_rd_en === 1'b1) got = 1'b1;
        else cyc();
      end
      check("rd_seen", 32'(got), 1);
      if (!got) return;
      check("rd_latency", cyc_n - t_wr_idle, 3);
      check("release_hold", cyc_n - t_rqst_fall, hold + 3);
      check("cnt_during_rd", iter_cnt, k - 1);
      for (int a = 0; a < LOAD_CYCLE; a++) begin
        check("rd_en", ram_rd_en, 1);
        check("rd_addr", ram_rd_addr, a);
        if (k == rst_iter && a == 30) begin
          rstn = 1'b0;
          cyc();
          check("rst_state", state, 0);
          check("rst_rd_en", ram_rd_en, 0);
          check("rst_addr", ram_rd_addr, 0);
          check("rst_cnt", iter_cnt, 0);
          check("rst_rqst", iter_rqst, 0);
          rstn = 1'b1;
          writer_reset();
          cyc();
          check("rst_idle", state, 0);
          return;
        end
        if (a == 10) begin iter_done = 1'b1; syndrome_ok = 1'b1; end
        cyc();
        iter_done = 1'b0; syndrome_ok = 1'b0;
      end
      check("proc_state", state, 5);
      check("proc_rd_en", ram_rd_en, 0);
      check("proc_addr", ram_rd_addr, 0);
      check("cnt_ignored", iter_cnt, k - 1);
      repeat ($urandom_range(0, 4)) begin
        syndrome_ok = 1'($urandom_range(0, 1));
        cyc();
        check("proc_wait", state, 5);
      end
      syndrome_ok = (k == ok_iter);
      iter_done = 1'b1;
      cyc();
      iter_done = 1'b0; syndrome_ok = 1'b0;
      check("iter_cnt", iter_cnt, k);
      if (k == ok_iter || k == ITER_MAX) begin
        check("done_pulse", decode_done, 1);
        check("term_pulse", iter_termination, 1);
        check("done_state", state, 6);
        cyc();
        check("idle_state", state, 0);
        check("done_low", decode_done, 0);
        check("term_low", iter_termination, 0);
        check("n_done", n_done, 1);
        check("n_term", n_term, 1);
        check("final_cnt", iter_cnt, exp_final);
        return;
      end
      check("next_rqst", iter_rqst, 1);
      check("next_state", state, 1);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout observed=%0d expected=0", cyc_n);
    $fatal(1, "bench timeout");
  end

  initial begin
    rstn = 1'b0; start = 1'b0; iter_done = 1'b0; syndrome_ok = 1'b0; wr_busy = 2'b00;
    repeat (3) @(posedge read_clk);
    #1;
    check("reset_state", state, 0);
    check("reset_rqst", iter_rqst, 0);
    check("reset_rd_en", ram_rd_en, 0);
    check("reset_addr", ram_rd_addr, 0);
    check("reset_cnt", iter_cnt, 0);
    check("reset_done", decode_done, 0);
    check("reset_term", iter_termination, 0);
    check("reset_err", handshake_err, 0);
    rstn = 1'b1;
    iter_done = 1'b1; syndrome_ok = 1'b1;
    cyc();
    iter_done = 1'b0; syndrome_ok = 1'b0;
    check("idle_hold", state, 0);
    check("idle_cnt", iter_cnt, 0);

    run_decode(3, 0, 0);    // early exit on 3rd iteration
    run_decode(11, 5, 0);   // max iterations, writer holds FIN 5 cycles
    run_decode(11, 0, 2);   // reset mid-READ at address 30
    run_decode(1, 2, 0);    // normal decode after reset
    for (int r = 0; r < 3; r++)
      run_decode(int'($urandom_range(1, 12)), int'($urandom_range(0, 6)), 0);

`ifdef VNU3_RD_WATCHDOG_EN
    w_stuck = 1'b1; wr_busy = 2'b00; n_done = 0; n_term = 0;
    start = 1'b1; cyc(); start = 1'b0;
    check("wd_req", state, 1);
    repeat (255) cyc();
    check("wd_pre_term", n_term, 0);
    check("wd_pre_state", state, 1);
    cyc();
    check("wd_term", iter_termination, 1);
    check("wd_err", handshake_err, 1);
    check("wd_idle", state, 0);
    check("wd_rqst", iter_rqst, 0);
    cyc();
    check("wd_term_low", iter_termination, 0);
    check("wd_err_sticky", handshake_err, 1);
    check("wd_no_done", n_done, 0);
    start = 1'b1; cyc(); start = 1'b0;
    check("wd_err_clr", handshake_err, 0);
    rstn = 1'b0; cyc(); rstn = 1'b1;
    w_stuck = 1'b0; writer_reset();
    cyc();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
